do_funct_sel_multi: RTL

//  Parametrised N-channel digital-output function selector; per channel, routes LEVEL, one of NUM_SRC

---
 rtl/do_funct_pkg.sv | 18 +
 rtl/do_funct_chan.sv | 149 ++++++++++++++
 rtl/do_funct_sel_multi.sv | 50 +++++
 3 files changed

// File: rtl/do_funct_pkg.sv
// Shared definitions for the digital-output function selector:
// function codes and per-channel state encoding.
package do_funct_pkg;

   localparam int FUNCT_LEVEL = 0;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DEAD  = 2'd1,
      ST_PULSE = 2'd2
   } chan_state_e;

   // The pulse code sits just above the last source code.
   function automatic int funct_pulse_code(input int num_src);
      return num_src + 1;
   endfunction

endpackage

// File: rtl/do_funct_chan.sv
// One output channel: config registers, RUN/DEAD/PULSE state machine,
// shared dead/pulse counter and registered output.
module do_funct_chan
   import do_funct_pkg::*;
#(
   parameter int NUM_SRC     = 10,
   parameter int SEL_W       = 4,
   parameter int DEAD_CYCLES = 4,
   parameter int PULSE_W     = 16
) (
   input  logic               xclk,
   input  logic               reset,
   input  logic               we_i,
   input  logic [SEL_W-1:0]   wr_func_i,
   input  logic               wr_level_i,
   input  logic               wr_invert_i,
   input  logic [PULSE_W-1:0] wr_pulse_len_i,
   input  logic [NUM_SRC-1:0] src_i,
   output logic               do_o,
   output logic               busy_o
);

   localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
   localparam int CNT_W  = (PULSE_W > DEAD_W) ? PULSE_W : DEAD_W;
   localparam logic [SEL_W-1:0] LEVEL_CODE = SEL_W'(FUNCT_LEVEL);
   localparam logic [SEL_W-1:0] PULSE_CODE = SEL_W'(funct_pulse_code(NUM_SRC));
   localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   chan_state_e        state_q, state_d;
   logic [SEL_W-1:0]   func_q, func_d;
   logic               level_q, level_d;
   logic               invert_q, invert_d;
   logic [PULSE_W-1:0] len_q, len_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               do_q, do_d;
   logic               busy_q, busy_d;

   // Undefined codes (including PULSE) route a constant 0.
   function automatic logic route(input logic [SEL_W-1:0] f,
                                  input logic             lvl,
                                  input logic [NUM_SRC-1:0] s);
      logic r;
      r = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         r = (f == SEL_W'(k + 1)) ? s[k] : r;
      end
      return (f == LEVEL_CODE) ? lvl : r;
   endfunction

   // Next-state and next-output decode.
   always_comb begin
      state_d  = state_q;
      func_d   = func_q;
      level_d  = level_q;
      invert_d = invert_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      do_d     = do_q;
      busy_d   = busy_q;
      if (we_i) begin
         func_d   = wr_func_i;
         level_d  = wr_level_i;
         invert_d = wr_invert_i;
         len_d    = wr_pulse_len_i;
         if ((state_q == ST_RUN) && (wr_func_i == func_q)) begin
            do_d   = route(wr_func_i, wr_level_i, src_i) ^ wr_invert_i;
            busy_d = 1'b0;
         end else begin
            state_d = ST_DEAD;
            cnt_d   = DEAD_LOAD;
            do_d    = 1'b0;
            busy_d  = 1'b1;
         end
      end else begin
         case (state_q)
            ST_RUN: begin
               do_d   = route(func_q, level_q, src_i) ^ invert_q;
               busy_d = 1'b0;
            end
            ST_DEAD: begin
               if (cnt_q == CNT_ONE) begin
                  if ((func_q == PULSE_CODE) && (len_q != '0)) begin
                     state_d = ST_PULSE;
                     cnt_d   = CNT_W'(len_q);
                     do_d    = ~invert_q;
                     busy_d  = 1'b1;
                  end else if (func_q == PULSE_CODE) begin
                     state_d = ST_RUN;
                     func_d  = LEVEL_CODE;
                     do_d    = level_q ^ invert_q;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = ST_RUN;
                     do_d    = route(func_q, level_q, src_i) ^ invert_q;
                     busy_d  = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
                  do_d  = 1'b0;
               end
            end
            ST_PULSE: begin
               if (cnt_q == CNT_ONE) begin
                  state_d = ST_RUN;
                  func_d  = LEVEL_CODE;
                  do_d    = level_q ^ invert_q;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
                  do_d  = ~invert_q;
               end
            end
            default: begin
               state_d = ST_RUN;
               do_d    = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State, config and output registers.
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         func_q   <= LEVEL_CODE;
         level_q  <= 1'b0;
         invert_q <= 1'b0;
         len_q    <= '0;
         cnt_q    <= '0;
         do_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         func_q   <= func_d;
         level_q  <= level_d;
         invert_q <= invert_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         do_q     <= do_d;
         busy_q   <= busy_d;
      end
   end

   assign do_o   = do_q;
   assign busy_o = busy_q;

endmodule

// File: rtl/do_funct_sel_multi.sv
// N-channel digital-output function selector: decodes the channel write
// strobe and instantiates one independent channel per output.
module do_funct_sel_multi
   import do_funct_pkg::*;
#(
   parameter int NUM_CH      = 8,
   parameter int NUM_SRC     = 10,
   parameter int SEL_W       = 4,
   parameter int DEAD_CYCLES = 4,
   parameter int PULSE_W     = 16,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               xclk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [CH_W-1:0]    wr_ch,
   input  logic [SEL_W-1:0]   wr_func,
   input  logic               wr_level,
   input  logic               wr_invert,
   input  logic [PULSE_W-1:0] wr_pulse_len,
   input  logic [NUM_SRC-1:0] function_signals_in,
   output logic [NUM_CH-1:0]  do_out,
   output logic [NUM_CH-1:0]  ch_busy
);

   // Addresses at or above NUM_CH match no channel and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic we_s;
      assign we_s = wr_en && (wr_ch == CH_W'(i));

      do_funct_chan #(
         .NUM_SRC    (NUM_SRC),
         .SEL_W      (SEL_W),
         .DEAD_CYCLES(DEAD_CYCLES),
         .PULSE_W    (PULSE_W)
      ) u_chan (
         .xclk          (xclk),
         .reset         (reset),
         .we_i          (we_s),
         .wr_func_i     (wr_func),
         .wr_level_i    (wr_level),
         .wr_invert_i   (wr_invert),
         .wr_pulse_len_i(wr_pulse_len),
         .src_i         (function_signals_in),
         .do_o          (do_out[i]),
         .busy_o        (ch_busy[i])
      );
   end

endmodule
